// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg -- shared definitions for the MIPS pipeline control slice.
// Holds the hazard FSM state encoding, the register-zero constant, the
// opcode constants for the control-flow and memory instructions, the
// pipeline-control bundle type and the helpers that produce it.
package mips_pipe_pkg;

  // Hazard controller FSM states; encoding 2'd3 is unused and treated as ERROR.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  // One cycle's worth of pipeline enables, flushes and freeze.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_hold;
  } hz_ctrl_t;

  // Global freeze: nothing advances, nothing is flushed.
  localparam hz_ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0,
                                     ifid_flush: 1'b0, idex_flush: 1'b0,
                                     pipe_hold: 1'b1};

  // Reset image: front end frozen and both pipeline registers flushed.
  localparam hz_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0,
                                      ifid_flush: 1'b1, idex_flush: 1'b1,
                                      pipe_hold: 1'b0};

  // A lw in EX whose destination is read by the instruction in ID.
  // Writes to r0 are discarded by the register file, so they never stall.
  function automatic logic load_use_hit(input logic       ex_mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt,
                                        input logic       id_uses_rt);
    logic hit;
    hit = ex_mem_read && (ex_rt != REG_ZERO) &&
          ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    return hit;
  endfunction

  // Control-flow resolution when memory is not stalling the pipe:
  // taken branch beats load-use beats jump beats normal flow.
  function automatic hz_ctrl_t flow_ctrl(input logic branch,
                                         input logic load_use,
                                         input logic jump);
    hz_ctrl_t c;
    c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
          idex_flush: 1'b0, pipe_hold: 1'b0};
    if (branch) begin
      // The branch squashes both younger instructions, so a simultaneous
      // load-use hazard on the squashed ID instruction is irrelevant.
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_write   = 1'b0;
      c.ifid_write = 1'b0;
      c.idex_flush = 1'b1;
    end else if (jump) begin
      c.ifid_flush = 1'b1;
    end else begin
      c.ifid_flush = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the pipeline datapath and hazard_ctrl.
// Inputs to the controller: ID source registers and decode flags, EX load
// and branch information, MEM-stage data-memory handshake.
// Outputs from the controller: pipeline enables/flushes/freeze, sticky
// timeout, FSM state and the two performance counters.
// master: datapath side; slave: hazard controller side.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_jump;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        pipe_hold;
  logic        mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
           mem_timeout, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
           mem_timeout, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sat_cnt.sv
// hazard_sat_cnt -- 16-bit event counter that sticks at 16'hFFFF.
// Ports: clk (rising edge), reset (synchronous, active high),
//        inc (count this cycle), cnt (current count).
module hazard_sat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_r;

  // Count enabled events, holding at full scale instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else if (inc && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- MIPS pipeline hazard controller.
// Resolves data-memory waits, taken branches, load-use hazards and jumps
// into PC/IF-ID enables, IF-ID/ID-EX flushes and a global pipeline freeze.
// A memory access that stays unready for more than MAX_WAIT consecutive
// wait cycles parks the FSM in ERROR with a sticky mem_timeout until reset.
// Ports: clk (rising edge), reset (synchronous, active high),
//        bus (hazard_ctrl_if.slave: all pipeline inputs and outputs).
// Parameter: MAX_WAIT (1..255) consecutive MEM_WAIT cycles allowed.
// Build option: define HAZARD_PERF_CNT_EN to include the stall/flush
// performance counters; otherwise both read as zero.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);
  import mips_pipe_pkg::*;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  hz_state_e  state_r;
  hz_state_e  state_nxt_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_nxt_s;
  logic       mem_timeout_r;
  logic       timeout_set_s;
  logic       load_use_s;
  hz_ctrl_t   flow_s;
  hz_ctrl_t   ctrl_s;

  assign load_use_s = load_use_hit(bus.ex_mem_read, bus.ex_rt, bus.id_rs,
                                   bus.id_rt, bus.id_uses_rt);
  assign flow_s     = flow_ctrl(bus.ex_branch_taken, load_use_s, bus.id_jump);

  // Output decode and next-state selection from registered state and live inputs.
  always_comb begin
    ctrl_s         = flow_s;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_set_s  = 1'b0;
    if (reset) begin
      ctrl_s         = CTRL_RESET;
      state_nxt_s    = ST_RUN;
      wait_cnt_nxt_s = 8'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            ctrl_s         = CTRL_HOLD;
            wait_cnt_nxt_s = 8'd0;
            state_nxt_s    = ST_MEM_WAIT;
          end else begin
            ctrl_s = flow_s;
          end
        end
        ST_MEM_WAIT: begin
          if (!bus.dmem_ready) begin
            // Frozen pipe: branch/load-use/jump are re-evaluated on release.
            ctrl_s = CTRL_HOLD;
            if (wait_cnt_r == MAX_WAIT_C) begin
              state_nxt_s   = ST_ERROR;
              timeout_set_s = 1'b1;
            end else begin
              wait_cnt_nxt_s = wait_cnt_r + 8'd1;
            end
          end else begin
            ctrl_s         = flow_s;
            wait_cnt_nxt_s = 8'd0;
            state_nxt_s    = ST_RUN;
          end
        end
        default: begin
          // ERROR and the unused encoding: frozen until reset.
          ctrl_s      = CTRL_HOLD;
          state_nxt_s = ST_ERROR;
        end
      endcase
    end
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

  assign bus.pc_write    = ctrl_s.pc_write;
  assign bus.ifid_write  = ctrl_s.ifid_write;
  assign bus.ifid_flush  = ctrl_s.ifid_flush;
  assign bus.idex_flush  = ctrl_s.idex_flush;
  assign bus.pipe_hold   = ctrl_s.pipe_hold;
  assign bus.mem_timeout = mem_timeout_r;
  assign bus.state       = state_r;

`ifdef HAZARD_PERF_CNT_EN
  logic        stall_inc_s;
  logic        flush_inc_s;
  logic [15:0] stall_cnt_s;
  logic [15:0] flush_cnt_s;

  assign stall_inc_s = ~ctrl_s.pc_write;
  assign flush_inc_s = ctrl_s.ifid_flush | ctrl_s.idex_flush;

  hazard_sat_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .cnt   (stall_cnt_s)
  );

  hazard_sat_cnt u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s),
    .cnt   (flush_cnt_s)
  );

  assign bus.stall_cnt = stall_cnt_s;
  assign bus.flush_cnt = flush_cnt_s;
`else
  assign bus.stall_cnt = 16'd0;
  assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- randomized scoreboard bench for hazard_ctrl.
// The stimulus process predicts each cycle's response from the rule-level
// reference model and queues it; a monitor on the falling edge pops and
// compares. Runs with MAX_WAIT=4; counter expectations follow
// HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  localparam int MAXW = 4;

  typedef struct packed {
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pipe_hold;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } exp_t;

  logic clk;
  logic reset;
  hazard_ctrl_if hif ();

  hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0 = running, 1 = waiting on memory, 2 = dead.
  int m_mode;
  int m_waited;
  int m_tmo;
  int m_stalls;
  int m_flushes;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 20)
        $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs, predict the response, advance the model.
  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic jp, input logic mr,
                      input logic [4:0] er, input logic br,
                      input logic rq, input logic rd);
    exp_t e;
    logic lu;
    logic frozen;
    reset = r;
    hif.id_rs = rs; hif.id_rt = rt; hif.id_uses_rt = ur; hif.id_jump = jp;
    hif.ex_mem_read = mr; hif.ex_rt = er; hif.ex_branch_taken = br;
    hif.dmem_req = rq; hif.dmem_ready = rd;

    lu = mr && (er != 5'd0) && ((er == rs) || (ur && (er == rt)));
    frozen = (m_mode == 2) || (m_mode == 0 && rq && !rd) || (m_mode == 1 && !rd);
    e.state       = 2'(m_mode);
    e.mem_timeout = (m_tmo != 0);
`ifdef HAZARD_PERF_CNT_EN
    e.stall_cnt = 16'(m_stalls);
    e.flush_cnt = 16'(m_flushes);
`else
    e.stall_cnt = 16'd0;
    e.flush_cnt = 16'd0;
`endif
    if (r)           {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.pipe_hold} = 5'b00110;
    else if (frozen) {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.pipe_hold} = 5'b00001;
    else if (br)     {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.pipe_hold} = 5'b11110;
    else if (lu)     {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.pipe_hold} = 5'b00010;
    else if (jp)     {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.pipe_hold} = 5'b11100;
    else             {e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush, e.pipe_hold} = 5'b11000;
    exp_q.push_back(e);

    if (r) begin
      m_mode = 0; m_waited = 0; m_tmo = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e.pc_write && m_stalls < 65535) m_stalls++;
      if ((e.ifid_flush || e.idex_flush) && m_flushes < 65535) m_flushes++;
      if (m_mode == 0) begin
        if (rq && !rd) begin m_mode = 1; m_waited = 0; end
      end else if (m_mode == 1) begin
        if (rd) m_mode = 0;
        else if (m_waited == MAXW) begin m_mode = 2; m_tmo = 1; end
        else m_waited++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented response against the queued prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_write",    16'(hif.pc_write),    16'(e.pc_write));
        chk("ifid_write",  16'(hif.ifid_write),  16'(e.ifid_write));
        chk("ifid_flush",  16'(hif.ifid_flush),  16'(e.ifid_flush));
        chk("idex_flush",  16'(hif.idex_flush),  16'(e.idex_flush));
        chk("pipe_hold",   16'(hif.pipe_hold),   16'(e.pipe_hold));
        chk("state",       16'(hif.state),       16'(e.state));
        chk("mem_timeout", 16'(hif.mem_timeout), 16'(e.mem_timeout));
        chk("stall_cnt",   hif.stall_cnt,        e.stall_cnt);
        chk("flush_cnt",   hif.flush_cnt,        e.flush_cnt);
      end
    end
  end

  initial begin : stim
    int wait_cycles;
    reset = 1'b1;
    hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_uses_rt = 1'b0; hif.id_jump = 1'b0;
    hif.ex_mem_read = 1'b0; hif.ex_rt = 5'd0; hif.ex_branch_taken = 1'b0;
    hif.dmem_req = 1'b0; hif.dmem_ready = 1'b1;
    m_mode = 0; m_waited = 0; m_tmo = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk);
    #1;

    // Reset image with hazardous inputs present.
    step(1, 5'd8, 5'd0, 0, 1, 1, 5'd8, 1, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    // Load-use on rs, then ex_rt = r0 (no stall), then rt with/without uses_rt.
    step(0, 5'd8, 5'd3, 0, 0, 1, 5'd8, 0, 0, 1);
    step(0, 5'd0, 5'd3, 0, 0, 1, 5'd0, 0, 0, 1);
    step(0, 5'd1, 5'd9, 1, 0, 1, 5'd9, 0, 0, 1);
    step(0, 5'd1, 5'd9, 0, 0, 1, 5'd9, 0, 0, 1);
    // Branch together with load-use, then jump, then normal.
    step(0, 5'd8, 5'd3, 0, 1, 1, 5'd8, 1, 0, 1);
    step(0, 5'd2, 5'd3, 0, 1, 0, 5'd0, 0, 0, 1);
    step(0, 5'd2, 5'd3, 1, 0, 0, 5'd0, 0, 0, 1);
    // Three unready cycles (branch ignored), then release with a branch.
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    step(0, 5'd4, 5'd0, 0, 1, 1, 5'd4, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    // Timeout: hold ready low until ERROR, stay there, then reset.
    for (int i = 0; i < 10; i++) step(0, 5'd5, 5'd0, 0, 1, 1, 5'd5, 1, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    // Reset in the middle of a wait.
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);

    // Random traffic over a small register range so hazards collide often.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 149) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
           5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
           1'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Counter saturation: park in ERROR for 70000 stall cycles.
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    for (int i = 0; i < 70000; i++) step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d responses left, wanted 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, giving the maximum consecutive data-memory wait cycles before timeout (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt (R-type, sw, beq, bne).
REQ-006 SHALL have port id_jump, input, 1 bit: j or jal is decoded in ID.
REQ-007 SHALL have ports ex_mem_read (input, 1 bit) and ex_rt (input, 5 bits): the EX instruction is a lw, and its destination register.
REQ-008 SHALL have port ex_branch_taken, input, 1 bit: a beq or bne resolved taken in EX.
REQ-009 SHALL have ports dmem_req (input, 1 bit, MEM-stage access active) and dmem_ready (input, 1 bit, access completes this cycle).
REQ-010 SHALL have outputs pc_write, ifid_write, ifid_flush, idex_flush and pipe_hold, 1 bit each: pipeline enables, flushes and global freeze.
REQ-011 SHALL have outputs mem_timeout (1 bit, sticky error) and state (2 bits, current FSM state).
REQ-012 SHALL have outputs stall_cnt and flush_cnt, 16 bits each: performance counters.

Function
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1 and ERROR=2, with 3 unused and decoding to ERROR.
REQ-014 SHALL make outputs combinational from the registered state, wait counter and current inputs, with next-state registered on clk.
REQ-015 SHALL use the following RUN priority order: memory wait, then branch, then load-use, then jump, then normal.
REQ-016 SHALL, in RUN with dmem_req=1 and dmem_ready=0, drive pipe_hold=1, pc_write=0, ifid_write=0 and no flushes, clear the wait counter, and go to MEM_WAIT.
REQ-017 SHALL, in RUN on a branch (ex_branch_taken=1), drive pc_write=1, ifid_write=1, ifid_flush=1 and idex_flush=1 in a single cycle.
REQ-018 SHALL detect load-use when ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
REQ-019 SHALL, on load-use, drive pc_write=0, ifid_write=0 and idex_flush=1 (bubble) for one cycle and stay in RUN.
REQ-020 SHALL, on a jump (id_jump=1, no higher-priority event), drive pc_write=1, ifid_write=1 and ifid_flush=1.
REQ-021 SHALL, in normal operation, drive pc_write=1 and ifid_write=1 with all flushes and pipe_hold at 0.
REQ-022 SHALL, in MEM_WAIT with dmem_ready=0, hold the pipeline exactly as in REQ-016, increment the wait counter, and ignore branch, load-use and jump.
REQ-023 SHALL, in MEM_WAIT with dmem_ready=1, release pipe_hold that cycle, evaluate branch, load-use and jump per REQ-015 (excluding memory wait), and return to RUN.
REQ-024 SHALL go to ERROR and set mem_timeout=1 when the wait counter equals MAX_WAIT and dmem_ready=0.
REQ-025 SHALL, in ERROR, drive pipe_hold=1, pc_write=0 and ifid_write=0 until reset.
REQ-026 SHALL count a stall cycle on any cycle with pc_write=0 and a flush on any cycle with ifid_flush or idex_flush asserted, each counter saturating at 0xFFFF.

Reset
REQ-027 SHALL, while reset=1, force state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0 and flush_cnt=0.
REQ-028 SHALL, while reset=1, force pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1 and pipe_hold=0, regardless of inputs.
REQ-029 SHALL, on reset asserted mid-MEM_WAIT or in ERROR, return to RUN on the next edge and discard the pending wait.

Configuration
REQ-030 SHALL compile in the performance counters only when HAZARD_PERF_CNT_EN is defined; when undefined, stall_cnt and flush_cnt SHALL be tied to 0 and no counter flops inferred.

Structure
REQ-031 SHALL take the state encodings, the register-zero constant (5'd0) and the lw/sw/beq/bne/j/jal opcode constants from shared package mips_pipe_pkg.
REQ-032 SHALL implement the saturating 16-bit counter as sub-module hazard_sat_cnt, instantiated twice under HAZARD_PERF_CNT_EN.

Verification
REQ-033 SHALL verify load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; with ex_rt=0 -> no stall.
REQ-034 SHALL verify branch vs. load-use: ex_branch_taken=1 and load-use true together -> ifid_flush=1, idex_flush=1, pc_write=1.
REQ-035 SHALL verify memory wait: dmem_req=1 with dmem_ready low for 3 cycles -> pipe_hold=1 for 3 cycles, state=1, then RUN on the ready cycle.
REQ-036 SHALL verify timeout: MAX_WAIT=4 with dmem_ready held low -> state=2 and mem_timeout=1 after 5 hold cycles, held until reset.
REQ-037 SHALL verify reset mid-wait: reset during MEM_WAIT -> next cycle state=0, mem_timeout=0 and counters at 0.
REQ-038 SHALL verify counters (macro defined): 70000 forced stall cycles -> stall_cnt=0xFFFF; macro undefined -> stall_cnt=0.
